mem_rdport: RTL and testbench

//  Responder end of the long-latency data read port driven by the LD unit:

---
 rtl/mem_rdport.sv | 131 +++++++++++++
 tb/tb_mem_rdport.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rdport.sv
// mem_rdport: responder end of the LD unit's long-latency read port.
//
// Every request sampled on mem_re is queued together with a timestamp taken
// from a free-running 16-bit timer. When the head entry has aged exactly
// LATENCY-1 cycles it is popped, and its response is broadcast for one cycle.
// The response becomes visible LATENCY cycles after the request edge.
// Because the latency is fixed and at most one request is accepted per cycle,
// at most one entry can pop per cycle. Responses therefore never collide and
// always return in issue order.
//
// Ports
//   clk           clock, all logic on posedge
//   rst_n         synchronous reset, active low
//   mem_re        read request valid (each high cycle is one request)
//   mem_raddr     16-bit word address of the request
//   mem_ready     one-cycle response strobe
//   mem_addr_out  address of the response being broadcast (held between strobes)
//   mem_data_out  data for mem_addr_out (held between strobes)
//   wr_en         backdoor write enable
//   wr_addr       backdoor write address
//   wr_data       backdoor write data
//   pending       outstanding-request count, 0..DEPTH
//   drop_err      sticky flag: a request arrived while the queue was full
module mem_rdport #(
    parameter int    LATENCY   = 100,
    parameter int    DEPTH     = 128,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_re,
    input  logic [15:0] mem_raddr,
    output logic        mem_ready,
    output logic [15:0] mem_addr_out,
    output logic [15:0] mem_data_out,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic [7:0]  pending,
    output logic        drop_err
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] AGE_ISSUE = 16'(LATENCY - 1);
    localparam logic [7:0]  DEPTH_CNT = 8'(DEPTH);

    logic [15:0]   mem_r     [0:65535];
    logic [15:0]   q_addr_r  [0:DEPTH-1];
    logic [15:0]   q_stamp_r [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [15:0]   timer_r;

    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic [15:0]   head_addr_s;
    logic [15:0]   age_s;

    // Queue status and issue decision. The age is taken modulo 2^16, so a
    // timer wrap between push and pop does not matter.
    always_comb begin
        full_s      = (pending == DEPTH_CNT);
        push_s      = mem_re & ~full_s;
        head_addr_s = q_addr_r[rd_ptr_r];
        age_s       = timer_r - q_stamp_r[rd_ptr_r];
        if (pending != 8'd0) begin
            pop_s = (age_s == AGE_ISSUE);
        end else begin
            pop_s = 1'b0;
        end
    end

    // Backdoor write into the storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Queue payload storage. Stale entries are harmless because the pointers
    // and the count decide validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_addr_r[wr_ptr_r]  <= mem_raddr;
            q_stamp_r[wr_ptr_r] <= timer_r;
        end
    end

    // Timer, queue pointers, occupancy, response outputs and the sticky drop flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_r      <= 16'd0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            pending      <= 8'd0;
            mem_ready    <= 1'b0;
            mem_addr_out <= 16'd0;
            mem_data_out <= 16'd0;
            drop_err     <= 1'b0;
        end else begin
            timer_r <= timer_r + 16'd1;

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end

            // The read uses the array value from before this edge, so a
            // same-edge backdoor write returns the old data.
            if (pop_s) begin
                rd_ptr_r     <= rd_ptr_r + 1'b1;
                mem_ready    <= 1'b1;
                mem_addr_out <= head_addr_s;
                mem_data_out <= mem_r[head_addr_s];
            end else begin
                mem_ready    <= 1'b0;
            end

            case ({push_s, pop_s})
                2'b10:   pending <= pending + 8'd1;
                2'b01:   pending <= pending - 8'd1;
                default: pending <= pending;
            endcase

            if (mem_re && full_s) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_rdport.sv
// tb_mem_rdport: randomized and directed bench for mem_rdport.
// Two instances are driven: the default one (LATENCY=100, DEPTH=128) and a
// small one (LATENCY=4, DEPTH=2) for the overflow scenario. The reference
// model does not use timestamps. It records the absolute edge number at which
// each accepted request is due and returns the model memory value at that edge.
module tb_mem_rdport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                wr_en;
    logic [15:0]         wr_addr;
    logic [15:0]         wr_data;
    logic [1:0]          re;
    logic [1:0][15:0]    raddr;
    logic [1:0]          rdy;
    logic [1:0][15:0]    aout;
    logic [1:0][15:0]    dout;
    logic [1:0][7:0]     pend;
    logic [1:0]          drp;

    mem_rdport #(.LATENCY(100), .DEPTH(128)) dut (
        .clk(clk), .rst_n(rst_n), .mem_re(re[0]), .mem_raddr(raddr[0]),
        .mem_ready(rdy[0]), .mem_addr_out(aout[0]), .mem_data_out(dout[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending(pend[0]), .drop_err(drp[0])
    );

    mem_rdport #(.LATENCY(4), .DEPTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .mem_re(re[1]), .mem_raddr(raddr[1]),
        .mem_ready(rdy[1]), .mem_addr_out(aout[1]), .mem_data_out(dout[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending(pend[1]), .drop_err(drp[1])
    );

    // Reference model state
    logic [15:0] mmem [0:65535];
    int          due_q [2][256];
    logic [15:0] adr_q [2][256];
    int          hd [2];
    int          tl [2];
    logic        e_rdy [2];
    logic [15:0] e_addr [2];
    logic [15:0] e_data [2];
    logic        e_drop [2];
    int          lat [2];
    int          dep [2];
    int          cyc;
    int          tmr;

    // Observation statistics per instance
    int          seen_rdy [2];
    logic [15:0] last_data [2];
    int          last_edge [2];
    int          max_pend [2];

    int          n_tests;
    int          n_fail;
    int          acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                hd[i] = 0; tl[i] = 0;
                e_rdy[i] = 1'b0; e_addr[i] = 16'd0; e_data[i] = 16'd0; e_drop[i] = 1'b0;
            end else begin
                int cnt;
                cnt = tl[i] - hd[i];
                if (cnt > 0 && due_q[i][hd[i] % 256] == cyc) begin
                    e_rdy[i]  = 1'b1;
                    e_addr[i] = adr_q[i][hd[i] % 256];
                    e_data[i] = mmem[e_addr[i]];
                    hd[i]++;
                end else begin
                    e_rdy[i] = 1'b0;
                end
                if (re[i]) begin
                    if (cnt < dep[i]) begin
                        due_q[i][tl[i] % 256] = cyc + lat[i] - 1;
                        adr_q[i][tl[i] % 256] = raddr[i];
                        tl[i]++;
                    end else begin
                        e_drop[i] = 1'b1;
                    end
                end
            end
        end
        if (wr_en) mmem[wr_addr] = wr_data;
        tmr = rst_n ? (tmr + 1) % 65536 : 0;
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rdy%0d", i),  32'(rdy[i]),  32'(e_rdy[i]));
            check($sformatf("addr%0d", i), 32'(aout[i]), 32'(e_addr[i]));
            check($sformatf("data%0d", i), 32'(dout[i]), 32'(e_data[i]));
            check($sformatf("pend%0d", i), 32'(pend[i]), 32'(tl[i] - hd[i]));
            check($sformatf("drop%0d", i), 32'(drp[i]),  32'(e_drop[i]));
            if (rdy[i]) begin
                seen_rdy[i]++;
                last_data[i] = dout[i];
                last_edge[i] = cyc - 1;
            end
            if (int'(pend[i]) > max_pend[i]) max_pend[i] = int'(pend[i]);
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < 2; i++) begin
            seen_rdy[i] = 0; last_data[i] = 16'd0; last_edge[i] = -1; max_pend[i] = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; tmr = 0;
        lat[0] = 100; dep[0] = 128; lat[1] = 4; dep[1] = 2;
        for (int i = 0; i < 2; i++) begin hd[i] = 0; tl[i] = 0; end
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 16'd0; wr_data = 16'd0;
        re = 2'b00; raddr = '0;
        clr_stats();
        @(negedge clk);
        idle(2);
        check("reset_pend", 32'(pend[0]), 32'd0);
        rst_n = 1'b1;

        // Preload every address the bench will read
        for (int a = 0; a < 64; a++) bd_write(16'(a), 16'($urandom));

        // 1: single read, exact latency
        bd_write(16'h0040, 16'hBEEF);
        clr_stats();
        re[0] = 1'b1; raddr[0] = 16'h0040;
        tick(); acc = cyc - 1;
        re[0] = 1'b0;
        idle(110);
        check("t1_count", 32'(seen_rdy[0]), 32'd1);
        check("t1_edge",  32'(last_edge[0]), 32'(acc + 99));
        check("t1_data",  32'(last_data[0]), 32'h0000BEEF);

        // 2: three consecutive reads, in-order responses
        clr_stats();
        for (int k = 0; k < 3; k++) begin
            re[0] = 1'b1; raddr[0] = 16'(16'h0010 + k);
            tick();
            if (k == 0) acc = cyc - 1;
        end
        re[0] = 1'b0;
        idle(110);
        check("t2_count", 32'(seen_rdy[0]), 32'd3);
        check("t2_peak",  32'(max_pend[0]), 32'd3);
        check("t2_last",  32'(last_edge[0]), 32'(acc + 101));
        check("t2_empty", 32'(pend[0]), 32'd0);

        // 3: overflow on the small instance
        clr_stats();
        for (int k = 0; k < 3; k++) begin
            re[1] = 1'b1; raddr[1] = 16'(5 + k);
            tick();
        end
        re[1] = 1'b0;
        idle(10);
        check("t3_count", 32'(seen_rdy[1]), 32'd2);
        check("t3_drop",  32'(drp[1]), 32'd1);
        check("t3_peak",  32'(max_pend[1]), 32'd2);
        check("t3_data",  32'(last_data[1]), 32'(mmem[16'd6]));

        // 4: reset in flight discards everything
        clr_stats();
        for (int k = 0; k < 5; k++) begin
            re[0] = 1'b1; raddr[0] = 16'(16'h0030 + k);
            tick();
        end
        re[0] = 1'b0;
        idle(45);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(130);
        check("t4_count", 32'(seen_rdy[0]), 32'd0);
        check("t4_pend",  32'(pend[0]), 32'd0);
        check("t4_drop",  32'(drp[1]), 32'd0);
        check("t4_addr",  32'(aout[0]), 32'd0);
        check("t4_data",  32'(dout[0]), 32'd0);

        // 6: write before the issue edge is seen, write on the issue edge is not
        for (int pass = 0; pass < 2; pass++) begin
            bd_write(16'h0020, 16'h1111);
            clr_stats();
            re[0] = 1'b1; raddr[0] = 16'h0020;
            tick();
            re[0] = 1'b0;
            for (int j = 1; j <= 110; j++) begin
                wr_en = (j == ((pass == 0) ? 50 : 99));
                wr_addr = 16'h0020; wr_data = 16'h2222;
                tick();
            end
            wr_en = 1'b0;
            check($sformatf("t6_count%0d", pass), 32'(seen_rdy[0]), 32'd1);
            check($sformatf("t6_data%0d", pass), 32'(last_data[0]),
                  (pass == 0) ? 32'h00002222 : 32'h00001111);
        end

        // Random traffic on both instances with concurrent backdoor writes
        for (int k = 0; k < 2000; k++) begin
            re[0] = ($urandom_range(1, 0) == 1);
            re[1] = ($urandom_range(2, 0) == 0);
            raddr[0] = 16'($urandom_range(63, 0));
            raddr[1] = 16'($urandom_range(63, 0));
            wr_en = ($urandom_range(3, 0) == 0);
            wr_addr = 16'($urandom_range(63, 0));
            wr_data = 16'($urandom);
            tick();
        end
        re = 2'b00; wr_en = 1'b0;
        idle(110);

        // 5: response across the timer wrap
        while (tmr != 16'hFFF0) tick();
        clr_stats();
        re[0] = 1'b1; raddr[0] = 16'h0001;
        tick(); acc = cyc - 1;
        re[0] = 1'b0;
        idle(110);
        check("t5_count", 32'(seen_rdy[0]), 32'd1);
        check("t5_edge",  32'(last_edge[0]), 32'(acc + 99));
        check("t5_data",  32'(last_data[0]), 32'(mmem[16'h0001]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
